// File: rtl/zeroriscy_trap_sequencer.sv
// Trap entry/exit sequencer: arbitrates exceptions, interrupts and MRET, and
// drives CSR save/restore strobes, PC redirect and interrupt acknowledge.
module zeroriscy_trap_sequencer #(
  parameter int unsigned N_IRQ          = 32,
  parameter bit          EXC_FROM_IF_OK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             irq_enable_i,
  input  logic             exc_valid_i,
  input  logic [4:0]       exc_cause_i,
  input  logic             exc_from_if_i,
  input  logic             mret_i,
  input  logic             boundary_i,
  output logic             irq_req_o,
  output logic             csr_save_cause_o,
  output logic             csr_save_if_o,
  output logic             csr_save_id_o,
  output logic [5:0]       csr_cause_o,
  output logic             csr_restore_mret_o,
  output logic             pc_set_o,
  output logic [1:0]       pc_sel_o,
  output logic [4:0]       exc_vec_o,
  output logic             irq_ack_o,
  output logic [4:0]       irq_id_o,
  output logic             busy_o
);

  localparam int unsigned ID_W    = 5;
  localparam int unsigned CAUSE_W = 6;
  localparam logic [1:0]  PC_NONE = 2'b00;
  localparam logic [1:0]  PC_TRAP = 2'b01;
  localparam logic [1:0]  PC_MEPC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IRQ_PEND,
    S_SAVE,
    S_JUMP,
    S_MRET
  } state_e;

  // Highest set index wins.
  function automatic logic [ID_W-1:0] f_highest(input logic [N_IRQ-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (v[i]) id = ID_W'(i);
    end
    return id;
  endfunction

  state_e               r_state,  w_state_nxt;
  logic                 r_is_irq, w_is_irq_nxt;
  logic                 r_src_if, w_src_if_nxt;
  logic [ID_W-1:0]      r_id,     w_id_nxt;
  logic [CAUSE_W-1:0]   r_cause,  w_cause_nxt;

  logic                 r_irq_req, r_save_cause, r_save_if, r_save_id;
  logic                 r_restore, r_pc_set, r_irq_ack, r_busy;
  logic [1:0]           r_pc_sel;
  logic [ID_W-1:0]      r_exc_vec, r_irq_id;

  logic                 w_irq_req, w_save_cause, w_save_if, w_save_id;
  logic                 w_restore, w_pc_set, w_irq_ack, w_busy;
  logic [1:0]           w_pc_sel;
  logic [ID_W-1:0]      w_exc_vec, w_irq_id;

  logic [N_IRQ-1:0]     w_pend;
  logic                 w_any_pend;
  logic [ID_W-1:0]      w_sel_id;
  logic                 w_exc_src_if;

  assign w_pend       = irq_i & {N_IRQ{irq_enable_i}};
  assign w_any_pend   = |w_pend;
  assign w_sel_id     = f_highest(w_pend);
  assign w_exc_src_if = exc_from_if_i && EXC_FROM_IF_OK;

  // State and latched-field register; outputs are registered from next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_is_irq     <= 1'b0;
      r_src_if     <= 1'b0;
      r_id         <= '0;
      r_cause      <= '0;
      r_irq_req    <= 1'b0;
      r_save_cause <= 1'b0;
      r_save_if    <= 1'b0;
      r_save_id    <= 1'b0;
      r_restore    <= 1'b0;
      r_pc_set     <= 1'b0;
      r_pc_sel     <= PC_NONE;
      r_exc_vec    <= '0;
      r_irq_ack    <= 1'b0;
      r_irq_id     <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_is_irq     <= w_is_irq_nxt;
      r_src_if     <= w_src_if_nxt;
      r_id         <= w_id_nxt;
      r_cause      <= w_cause_nxt;
      r_irq_req    <= w_irq_req;
      r_save_cause <= w_save_cause;
      r_save_if    <= w_save_if;
      r_save_id    <= w_save_id;
      r_restore    <= w_restore;
      r_pc_set     <= w_pc_set;
      r_pc_sel     <= w_pc_sel;
      r_exc_vec    <= w_exc_vec;
      r_irq_ack    <= w_irq_ack;
      r_irq_id     <= w_irq_id;
      r_busy       <= w_busy;
    end
  end

  // Next state, latched fields, and Moore output decode of the next state.
  always_comb begin
    w_state_nxt  = r_state;
    w_is_irq_nxt = r_is_irq;
    w_src_if_nxt = r_src_if;
    w_id_nxt     = r_id;
    w_cause_nxt  = r_cause;

    unique case (r_state)
      S_IDLE: begin
        if (exc_valid_i) begin
          w_is_irq_nxt = 1'b0;
          w_src_if_nxt = w_exc_src_if;
          w_cause_nxt  = {1'b0, exc_cause_i};
          w_state_nxt  = S_SAVE;
        end else if (mret_i) begin
          w_state_nxt  = S_MRET;
        end else if (w_any_pend) begin
          w_id_nxt     = w_sel_id;
          w_state_nxt  = S_IRQ_PEND;
        end
      end
      S_IRQ_PEND: begin
        if (exc_valid_i) begin
          w_is_irq_nxt = 1'b0;
          w_src_if_nxt = w_exc_src_if;
          w_cause_nxt  = {1'b0, exc_cause_i};
          w_state_nxt  = S_SAVE;
        end else if (!w_any_pend) begin
          w_state_nxt  = S_IDLE;
        end else if (boundary_i) begin
          w_id_nxt     = w_sel_id;
          w_is_irq_nxt = 1'b1;
          w_src_if_nxt = 1'b1;
          w_cause_nxt  = {1'b1, w_sel_id};
          w_state_nxt  = S_SAVE;
        end else begin
          w_id_nxt     = w_sel_id;
        end
      end
      S_SAVE:  w_state_nxt = S_JUMP;
      S_JUMP:  w_state_nxt = S_IDLE;
      S_MRET:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_irq_req    = (w_state_nxt == S_IRQ_PEND);
    w_save_cause = (w_state_nxt == S_SAVE);
    w_save_if    = (w_state_nxt == S_SAVE) &&  w_src_if_nxt;
    w_save_id    = (w_state_nxt == S_SAVE) && !w_src_if_nxt;
    w_restore    = (w_state_nxt == S_MRET);
    w_pc_set     = (w_state_nxt == S_JUMP) || (w_state_nxt == S_MRET);
    w_pc_sel     = (w_state_nxt == S_JUMP) ? PC_TRAP :
                   (w_state_nxt == S_MRET) ? PC_MEPC : PC_NONE;
    w_irq_ack    = (w_state_nxt == S_JUMP) && w_is_irq_nxt;
    w_exc_vec    = w_irq_ack ? w_id_nxt : '0;
    w_irq_id     = w_irq_ack ? w_id_nxt : '0;
    w_busy       = (w_state_nxt != S_IDLE);
  end

  assign irq_req_o          = r_irq_req;
  assign csr_save_cause_o   = r_save_cause;
  assign csr_save_if_o      = r_save_if;
  assign csr_save_id_o      = r_save_id;
  assign csr_cause_o        = r_cause;
  assign csr_restore_mret_o = r_restore;
  assign pc_set_o           = r_pc_set;
  assign pc_sel_o           = r_pc_sel;
  assign exc_vec_o          = r_exc_vec;
  assign irq_ack_o          = r_irq_ack;
  assign irq_id_o           = r_irq_id;
  assign busy_o             = r_busy;

endmodule

// File: tb/tb_zeroriscy_trap_sequencer.sv
// Scoreboard bench for zeroriscy_trap_sequencer: expected strobe cycles are
// queued with the stimulus and compared whenever the DUT emits a strobe.
module tb_zeroriscy_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq_i = '0;
  logic        irq_enable_i = 1'b0;
  logic        exc_valid_i = 1'b0;
  logic [4:0]  exc_cause_i = '0;
  logic        exc_from_if_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        boundary_i = 1'b0;
  logic        irq_req_o, csr_save_cause_o, csr_save_if_o, csr_save_id_o;
  logic [5:0]  csr_cause_o;
  logic        csr_restore_mret_o, pc_set_o, irq_ack_o, busy_o;
  logic [1:0]  pc_sel_o;
  logic [4:0]  exc_vec_o, irq_id_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] sb_q[$];

  zeroriscy_trap_sequencer dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .irq_enable_i(irq_enable_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .exc_from_if_i(exc_from_if_i), .mret_i(mret_i), .boundary_i(boundary_i),
    .irq_req_o(irq_req_o), .csr_save_cause_o(csr_save_cause_o),
    .csr_save_if_o(csr_save_if_o), .csr_save_id_o(csr_save_id_o),
    .csr_cause_o(csr_cause_o), .csr_restore_mret_o(csr_restore_mret_o),
    .pc_set_o(pc_set_o), .pc_sel_o(pc_sel_o), .exc_vec_o(exc_vec_o),
    .irq_ack_o(irq_ack_o), .irq_id_o(irq_id_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Record: {save_cause, save_if, save_id, cause[5:0], restore, pc_set, pc_sel, exc_vec, ack, irq_id}
  function automatic logic [23:0] rec(input logic sc, input logic sif, input logic sid,
                                      input logic [5:0] cause, input logic rst,
                                      input logic ps, input logic [1:0] sel,
                                      input logic [4:0] vec, input logic ack,
                                      input logic [4:0] id);
    return {sc, sif, sid, cause, rst, ps, sel, vec, ack, id};
  endfunction

  function automatic logic [23:0] obs_rec();
    return {csr_save_cause_o, csr_save_if_o, csr_save_id_o, csr_cause_o,
            csr_restore_mret_o, pc_set_o, pc_sel_o, exc_vec_o, irq_ack_o, irq_id_o};
  endfunction

  function automatic logic [23:0] exp_save(input logic src_if, input logic [5:0] cause);
    return rec(1'b1, src_if, !src_if, cause, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 5'd0);
  endfunction

  function automatic logic [23:0] exp_jump(input logic [5:0] cause, input logic is_irq,
                                           input logic [4:0] id);
    return rec(1'b0, 1'b0, 1'b0, cause, 1'b0, 1'b1, 2'b01,
               is_irq ? id : 5'd0, is_irq, is_irq ? id : 5'd0);
  endfunction

  function automatic logic [23:0] exp_mret(input logic [5:0] cause);
    return rec(1'b0, 1'b0, 1'b0, cause, 1'b1, 1'b1, 2'b10, 5'd0, 1'b0, 5'd0);
  endfunction

  // Any strobe cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (csr_save_cause_o || csr_save_if_o || csr_save_id_o || csr_restore_mret_o ||
        pc_set_o || irq_ack_o) begin
      if (sb_q.size() == 0) chk("sb_unexpected", 32'(obs_rec()), 32'h0);
      else                  chk("sb_event", 32'(obs_rec()), 32'(sb_q.pop_front()));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2;
    chk("rst_outputs", 32'(obs_rec()), 32'h0);
    chk("rst_busy_req", 32'({busy_o, irq_req_o}), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    step(1);

    // Exception from ID stage
    sb_q.push_back(exp_save(1'b0, 6'h02));
    sb_q.push_back(exp_jump(6'h02, 1'b0, 5'd0));
    exc_valid_i = 1'b1; exc_cause_i = 5'h02; exc_from_if_i = 1'b0;
    step(1);
    exc_valid_i = 1'b0;
    chk("exc_busy", 32'(busy_o), 32'h1);
    step(2);
    chk("exc_idle", 32'(busy_o), 32'h0);

    // Highest of lines 3 and 17 taken at boundary
    irq_i = 32'h0002_0008; irq_enable_i = 1'b1;
    step(1);
    chk("irq_req_1", 32'(irq_req_o), 32'h1);
    step(1);
    chk("irq_req_2", 32'(irq_req_o), 32'h1);
    sb_q.push_back(exp_save(1'b1, 6'h31));
    sb_q.push_back(exp_jump(6'h31, 1'b1, 5'd17));
    boundary_i = 1'b1;
    step(1);
    boundary_i = 1'b0; irq_i = '0;
    chk("irq_req_save", 32'(irq_req_o), 32'h0);
    step(2);
    chk("irq_idle", 32'({busy_o, irq_req_o}), 32'h0);

    // Masked line, then withdrawal before boundary
    irq_enable_i = 1'b0; irq_i = 32'h20;
    step(2);
    chk("mask_req", 32'({busy_o, irq_req_o}), 32'h0);
    irq_enable_i = 1'b1;
    step(1);
    chk("unmask_req", 32'(irq_req_o), 32'h1);
    irq_i = '0;
    step(1);
    chk("withdraw", 32'({busy_o, irq_req_o}), 32'h0);
    step(2);

    // Exception overrides pending interrupt; interrupt re-requested afterwards
    irq_i = 32'h80;
    step(1);
    chk("ovr_pend", 32'(irq_req_o), 32'h1);
    sb_q.push_back(exp_save(1'b1, 6'h0B));
    sb_q.push_back(exp_jump(6'h0B, 1'b0, 5'd0));
    exc_valid_i = 1'b1; exc_cause_i = 5'h0B; exc_from_if_i = 1'b1;
    step(1);
    exc_valid_i = 1'b0; exc_from_if_i = 1'b0;
    chk("ovr_req_save", 32'(irq_req_o), 32'h0);
    step(2);
    chk("ovr_idle", 32'(busy_o), 32'h0);
    step(1);
    chk("ovr_rereq", 32'(irq_req_o), 32'h1);
    irq_i = '0;
    step(2);

    // MRET, then MRET colliding with an exception
    sb_q.push_back(exp_mret(6'h0B));
    mret_i = 1'b1;
    step(1);
    mret_i = 1'b0;
    chk("mret_busy", 32'(busy_o), 32'h1);
    step(1);
    sb_q.push_back(exp_save(1'b0, 6'h04));
    sb_q.push_back(exp_jump(6'h04, 1'b0, 5'd0));
    mret_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 5'h04;
    step(1);
    mret_i = 1'b0; exc_valid_i = 1'b0;
    step(3);

    // Reset asserted while in SAVE
    sb_q.push_back(exp_save(1'b0, 6'h06));
    exc_valid_i = 1'b1; exc_cause_i = 5'h06;
    step(1);
    exc_valid_i = 1'b0;
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_out", 32'(obs_rec()), 32'h0);
    chk("rst_mid_busy", 32'(busy_o), 32'h0);
    step(1);
    @(negedge clk); rst_n = 1'b1;
    step(4);
    chk("post_rst_busy", 32'(busy_o), 32'h0);
    chk("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zeroriscy_trap_sequencer.md
Name: zeroriscy_trap_sequencer

Overview:
- Sequences trap entry and exit for the zero-riscy core.
- Arbitrates between synchronous exceptions, external interrupt lines and MRET.
- Drives the CSR save/restore strobes (mepc/mcause/mstatus update) and the PC redirect.
- Sits between the decoder/controller and the control-status register file; acknowledges interrupts back to the event unit.

Parameters:
- N_IRQ, 32, number of level-sensitive interrupt lines (1..32).
- EXC_FROM_IF_OK, 1, when 0 the exc_from_if_i input is ignored and all exceptions save the ID PC.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- irq_i  input  N_IRQ  level interrupt requests.
- irq_enable_i  input  1  global M-mode interrupt enable (mstatus.MIE).
- exc_valid_i  input  1  synchronous exception raised this cycle.
- exc_cause_i  input  5  exception code.
- exc_from_if_i  input  1  exception belongs to IF-stage PC (else ID).
- mret_i  input  1  MRET decoded in ID, single-cycle pulse.
- boundary_i  input  1  core is at an instruction boundary, interrupt may be taken.
- irq_req_o  output  1  interrupt pending, core must stall at next boundary.
- csr_save_cause_o  output  1  write mepc/mcause, push MIE to MPIE.
- csr_save_if_o  output  1  mepc source = IF PC.
- csr_save_id_o  output  1  mepc source = ID PC.
- csr_cause_o  output  6  {interrupt flag, code[4:0]}.
- csr_restore_mret_o  output  1  pop MPIE into MIE.
- pc_set_o  output  1  PC redirect strobe.
- pc_sel_o  output  2  00 none, 01 trap vector, 10 mepc.
- exc_vec_o  output  5  vector offset index.
- irq_ack_o  output  1  interrupt taken pulse to event unit.
- irq_id_o  output  5  id of acknowledged interrupt.
- busy_o  output  1  FSM not in IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0; latched cause/id/source cleared. All outputs registered (Moore, decoded from state plus latched fields).
- Effective pending: pend = irq_i & {N_IRQ{irq_enable_i}}. Selected id = highest set index. Interrupt cause = {1'b1, id}. Exception cause = {1'b0, exc_cause_i}.
- States: IDLE, IRQ_PEND, SAVE, JUMP, MRET.
- IDLE:
  - exc_valid_i: latch exception cause; latch source (IF if exc_from_if_i && EXC_FROM_IF_OK, else ID); go to SAVE.
  - else mret_i: go to MRET.
  - else |pend: latch id; go to IRQ_PEND.
  - Priority is exception > MRET > interrupt; a losing simultaneous event is dropped, not queued.
- IRQ_PEND:
  - irq_req_o = 1.
  - Re-evaluate id every cycle (a higher line arriving replaces the latched id).
  - exc_valid_i: overrides, latches exception cause/source, goes to SAVE, interrupt remains for later re-detection.
  - else pend == 0 (line dropped or MIE cleared): back to IDLE, no ack.
  - else boundary_i: latch final id, source = IF, go to SAVE.
- SAVE (1 cycle): csr_save_cause_o = 1, csr_cause_o = latched cause, exactly one of csr_save_if_o/csr_save_id_o = 1. Goes to JUMP.
- JUMP (1 cycle):
  - pc_set_o = 1, pc_sel_o = 01.
  - exc_vec_o = id for interrupts, 0 for exceptions.
  - For interrupts: irq_ack_o = 1, irq_id_o = id.
  - Goes to IDLE.
- MRET (1 cycle): csr_restore_mret_o = 1, pc_set_o = 1, pc_sel_o = 10. Goes to IDLE.
- Inputs other than those listed per state are ignored outside IDLE/IRQ_PEND.
- Trap-to-trap spacing: minimum 3 cycles (IDLE -> SAVE -> JUMP -> IDLE).
- Latency: exception detected -> save strobe 1 cycle later -> pc_set 2 cycles later. Interrupt: boundary_i -> save next cycle.
- busy_o = (state != IDLE).
- Reset asserted mid-sequence: immediate return to IDLE with all outputs 0. No partial save strobe or ack is produced after reset release.
- csr_cause_o holds its latched value outside SAVE; consumers qualify it with csr_save_cause_o.

Test Plan:
- Exception: exc_valid_i=1, exc_cause_i=0x02, exc_from_if_i=0 in IDLE -> next cycle csr_save_cause_o=1, csr_save_id_o=1, csr_cause_o=0x02; following cycle pc_set_o=1, pc_sel_o=01, exc_vec_o=0, irq_ack_o=0.
- Interrupt priority: irq_i bits 3 and 17 set, irq_enable_i=1, boundary_i=1 two cycles later -> irq_req_o=1 while pending; csr_cause_o=0x31, csr_save_if_o=1; then irq_ack_o=1, irq_id_o=17, exc_vec_o=17.
- Masking/withdrawal: irq_i[5]=1 with irq_enable_i=0 -> no irq_req_o. Enable, then drop irq_i[5] before boundary_i -> IRQ_PEND back to IDLE, no save, no ack.
- Override: in IRQ_PEND, exc_valid_i=1, cause 0x0B -> csr_cause_o=0x0B (flag 0), no irq_ack_o; the interrupt is re-requested after returning to IDLE.
- MRET: mret_i in IDLE -> next cycle csr_restore_mret_o=1, pc_set_o=1, pc_sel_o=10. mret_i together with exc_valid_i -> exception sequence only.
- Reset mid-operation: assert rst_n=0 during SAVE -> all outputs 0 immediately, busy_o=0; after release, no stray pc_set_o or irq_ack_o.
